// File: rtl/bcd_to_binary_if.sv
// Handshake/data bundle for the sequential BCD-to-binary converter.
// The requester drives start and the ten digits; the converter drives result and status.
interface bcd_to_binary_if;
    logic        start;
    logic [3:0]  x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
    logic [31:0] binary;
    logic        busy;
    logic        done;
    logic        invalid;
    logic        overflow;

    modport master (
        output start, x0, x1, x2, x3, x4, x5, x6, x7, x8, x9,
        input  binary, busy, done, invalid, overflow
    );

    modport slave (
        input  start, x0, x1, x2, x3, x4, x5, x6, x7, x8, x9,
        output binary, busy, done, invalid, overflow
    );
endinterface

// File: rtl/bcd_to_binary.sv
// 10-digit BCD to 32-bit binary, reverse double-dabble, one bit per cycle (35-cycle latency).
// Optional macro BCD2BIN_SATURATE_EN: clamp binary to 32'hFFFFFFFF on overflow.
module bcd_to_binary (
    input  logic            clock,
    input  logic            reset,
    bcd_to_binary_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [39:0] bcd_q;
    logic [33:0] bin_q;
    logic [5:0]  cnt_q;
    logic        bad_q;
    logic [31:0] binary_q;
    logic        busy_q, done_q, invalid_q, overflow_q;

    logic [39:0] digits_in;
    logic        digit_bad;
    logic [39:0] bcd_shr;
    logic [39:0] bcd_d;
    logic [33:0] bin_d;
    logic        ovf;
    logic [31:0] result;

    always_comb begin
        digits_in = {bus.x9, bus.x8, bus.x7, bus.x6, bus.x5,
                     bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
        digit_bad = 1'b0;
        for (int i = 0; i < 10; i++)
            if (digits_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end

    // Shift {bcd, bin} right one bit, then pull every digit that became >= 8 back by 3.
    always_comb begin
        bcd_shr = {1'b0, bcd_q[39:1]};
        bin_d   = {bcd_q[0], bin_q[33:1]};
        bcd_d   = bcd_shr;
        for (int i = 0; i < 10; i++)
            if (bcd_shr[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
    end

    always_comb begin
        ovf = (|bin_q[33:32]) & ~bad_q;
        if (bad_q)
            result = 32'd0;
`ifdef BCD2BIN_SATURATE_EN
        else if (ovf)
            result = 32'hFFFF_FFFF;
`endif
        else
            result = bin_q[31:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            binary_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= bus.start;
                    if (bus.start) begin
                        bcd_q   <= digits_in;
                        bin_q   <= '0;
                        cnt_q   <= '0;
                        bad_q   <= digit_bad;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b1;
                    bcd_q  <= bcd_d;
                    bin_q  <= bin_d;
                    cnt_q  <= cnt_q + 6'd1;
                    // Full 34 iterations regardless of bad so latency never varies.
                    if (cnt_q == 6'd33) state_q <= DONE;
                end
                DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b1;
                    binary_q   <= result;
                    invalid_q  <= bad_q;
                    overflow_q <= ovf;
                    state_q    <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.binary   = binary_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.invalid  = invalid_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, busy window, results, flags, ignored start, mid-run reset.
module tb_bcd_to_binary;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    bcd_to_binary_if bus();

    bcd_to_binary dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_digits(input logic [39:0] d);
        bus.x0 = d[3:0];   bus.x1 = d[7:4];   bus.x2 = d[11:8];  bus.x3 = d[15:12];
        bus.x4 = d[19:16]; bus.x5 = d[23:20]; bus.x6 = d[27:24]; bus.x7 = d[31:28];
        bus.x8 = d[35:32]; bus.x9 = d[39:36];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        set_digits(40'h0);
        repeat (3) @(posedge clock);
        #1;
        checks += 5;
        if (bus.binary !== 32'd0) begin errors++; $display("FAIL reset_binary got %h want 0", bus.binary); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", bus.invalid); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    // One conversion: start on edge k, sample #1 after edges k..k+36.
    task automatic test_vector(input string name, input logic [39:0] d,
                               input logic [31:0] exp_bin, input logic exp_inv, input logic exp_ovf);
        int lat, busy_cnt, done_cnt;
        set_digits(d);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        set_digits(40'h9999999999);
        lat = -1;
        busy_cnt = bus.busy ? 1 : 0;
        done_cnt = 0;
        for (int n = 1; n <= 36; n++) begin
            @(posedge clock);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (lat < 0) lat = n;
            end
        end
        checks += 6;
        if (lat !== 35) begin errors++; $display("FAIL %s latency got %0d want 35", name, lat); end
        if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
        if (busy_cnt !== 36) begin errors++; $display("FAIL %s busy_cycles got %0d want 36", name, busy_cnt); end
        if (bus.binary !== exp_bin) begin errors++; $display("FAIL %s binary got %h want %h", name, bus.binary, exp_bin); end
        if (bus.invalid !== exp_inv) begin errors++; $display("FAIL %s invalid got %b want %b", name, bus.invalid, exp_inv); end
        if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL %s overflow got %b want %b", name, bus.overflow, exp_ovf); end
    endtask

    task automatic test_convert();
        test_vector("zero", 40'h0000000000, 32'h0000_0000, 1'b0, 1'b0);
        test_vector("basic", 40'h0012345678, 32'h00BC_614E, 1'b0, 1'b0);
        test_vector("one", 40'h0000000001, 32'h0000_0001, 1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        test_vector("max32", 40'h4294967295, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef BCD2BIN_SATURATE_EN
        test_vector("max32p1", 40'h4294967296, 32'hFFFF_FFFF, 1'b0, 1'b1);
        test_vector("all9", 40'h9999999999, 32'hFFFF_FFFF, 1'b0, 1'b1);
`else
        test_vector("max32p1", 40'h4294967296, 32'h0000_0000, 1'b0, 1'b1);
        test_vector("all9", 40'h9999999999, 32'h540B_E3FF, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_invalid();
        test_vector("invalid_x3", 40'h000000A000, 32'h0000_0000, 1'b1, 1'b0);
        test_vector("invalid_x9", 40'hF000000001, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_start();
        int lat;
        set_digits(40'h0012345678);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 36; n++) begin
            @(posedge clock);
            #1;
            if (bus.done && lat < 0) lat = n;
            if (n == 9) begin
                set_digits(40'h0000000007);
                bus.start = 1'b1;
            end else if (n == 10) begin
                bus.start = 1'b0;
            end
        end
        checks += 3;
        if (lat !== 35) begin errors++; $display("FAIL ignored_start latency got %0d want 35", lat); end
        if (bus.binary !== 32'h00BC_614E) begin errors++; $display("FAIL ignored_start binary got %h want 00bc614e", bus.binary); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start busy_after got %b want 0", bus.busy); end
    endtask

    task automatic test_mid_reset();
        int done_cnt, busy_cnt;
        set_digits(40'h4294967296);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks += 5;
        if (bus.binary !== 32'd0) begin errors++; $display("FAIL midreset_binary got %h want 0", bus.binary); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
        if (bus.invalid !== 1'b0) begin errors++; $display("FAIL midreset_invalid got %b want 0", bus.invalid); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got %b want 0", bus.overflow); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        checks += 2;
        if (done_cnt !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", done_cnt); end
        if (busy_cnt !== 0) begin errors++; $display("FAIL midreset_idle_busy got %0d want 0", busy_cnt); end
`ifdef BCD2BIN_SATURATE_EN
        test_vector("after_reset", 40'h9999999999, 32'hFFFF_FFFF, 1'b0, 1'b1);
`else
        test_vector("after_reset", 40'h9999999999, 32'h540B_E3FF, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_convert();
        test_boundary();
        test_invalid();
        test_ignored_start();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
